// File: rtl/wb_pwm_bank_pkg.sv
// Shared register map, ID/fill constants and bus-request decode for the dithered-PWM bank.
package wb_pwm_bank_pkg;

    typedef enum logic [1:0] {
        REG_INC  = 2'd0,
        REG_ACC  = 2'd1,
        REG_LFSR = 2'd2,
        REG_CTRL = 2'd3
    } ch_reg_e;

    typedef enum logic [1:0] {
        G_ID   = 2'd0,
        G_STAT = 2'd1,
        G_EN   = 2'd2,
        G_RSVD = 2'd3
    } glb_reg_e;

    localparam logic [15:0] ID_MAGIC = 16'hB0A1;
    localparam logic [31:0] FILL     = 32'hDEADBEEF;
    localparam int          CTRL_EN  = 0;
    localparam int          CTRL_INV = 1;

    typedef struct packed {
        logic        we;
        logic        glb;
        logic [3:0]  ch;
        logic [1:0]  off;
        logic [31:0] dat;
    } wb_req_t;

    // adr holds byte-address bits [8:2]
    function automatic wb_req_t wb_decode(input logic [6:0] adr, input logic we,
                                          input logic [31:0] dat);
        wb_req_t r;
        r.we  = we;
        r.glb = adr[6];
        r.ch  = adr[5:2];
        r.off = adr[1:0];
        r.dat = dat;
        return r;
    endfunction

endpackage

// File: rtl/wb_pwm_bank_if.sv
// Wishbone classic single-beat bus bundle between the WB master and the PWM bank.
interface wb_pwm_bank_if;
    logic [16:0] wb_adr;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;

    modport master (output wb_adr, wb_cyc, wb_stb, wb_we, wb_dat_i,
                    input  wb_dat_o, wb_ack);
    modport slave  (input  wb_adr, wb_cyc, wb_stb, wb_we, wb_dat_i,
                    output wb_dat_o, wb_ack);
endinterface

// File: rtl/wb_pwm_bank_dither_ch.sv
// One dithered-PWM channel: phase accumulator vs Galois LFSR, register write port, wrap pulse.
module wb_pwm_bank_dither_ch
    import wb_pwm_bank_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] LFSR_POLY = 32'h008345E9,
    parameter int unsigned RST_INC   = 4096
) (
    input  logic             clk1,
    input  logic             rst1_n,
    input  logic             wr_en,
    input  ch_reg_e          wr_off,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] lfsr,
    output logic [1:0]       ctrl,
    output logic             wrap,
    output logic             pwm
);

    localparam logic [WIDTH-1:0] POLY = LFSR_POLY[WIDTH-1:0];

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lfsr_nxt;
    logic             en, inv, upd;

    assign en       = ctrl[CTRL_EN];
    assign inv      = ctrl[CTRL_INV];
    assign upd      = en & ~wr_en;
    assign sum      = {1'b0, acc} + {1'b0, inc};
    assign lfsr_nxt = {lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? POLY : '0);
    assign wrap     = upd & sum[WIDTH];

    always_ff @(posedge clk1) begin
        if (!rst1_n) begin
            inc  <= WIDTH'(RST_INC);
            acc  <= '0;
            lfsr <= '1;
            ctrl <= '0;
            pwm  <= 1'b0;
        end else begin
            pwm <= (en & (lfsr < acc)) ^ inv;
            if (wr_en) begin
                case (wr_off)
                    REG_INC:  inc  <= wr_dat;
                    REG_ACC:  acc  <= wr_dat;
                    // an all-zero Galois LFSR never leaves zero
                    REG_LFSR: lfsr <= (wr_dat == '0) ? '1 : wr_dat;
                    REG_CTRL: ctrl <= wr_dat[1:0];
                    default:  ;
                endcase
            end else if (en) begin
                acc  <= sum[WIDTH-1:0];
                lfsr <= lfsr_nxt;
            end
        end
    end

endmodule

// File: rtl/wb_pwm_bank.sv
// Wishbone slave bank of NUM_CH dithered-PWM channels with ID and optional wrap IRQ.
// Optional feature: define PWM_BANK_IRQ_EN for sticky wrap status, enable mask and irq_o.
module wb_pwm_bank
    import wb_pwm_bank_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] LFSR_POLY = 32'h008345E9,
    parameter int unsigned RST_INC   = 4096
) (
    input  logic              clk1,
    input  logic              rst1_n,
    wb_pwm_bank_if.slave      wb,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq_o
);

    wb_req_t rq;
    logic    req;

    assign rq  = wb_decode(wb.wb_adr[8:2], wb.wb_we, wb.wb_dat_i);
    assign req = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack;

    logic [NUM_CH-1:0][WIDTH-1:0] inc_a, acc_a, lfsr_a;
    logic [NUM_CH-1:0][1:0]       ctrl_a;
    logic [NUM_CH-1:0]            wrap_a, ch_wr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_wr[gi] = req & rq.we & ~rq.glb & (rq.ch == 4'(gi));

        wb_pwm_bank_dither_ch #(
            .WIDTH     (WIDTH),
            .LFSR_POLY (LFSR_POLY),
            .RST_INC   (RST_INC)
        ) u_ch (
            .clk1   (clk1),
            .rst1_n (rst1_n),
            .wr_en  (ch_wr[gi]),
            .wr_off (ch_reg_e'(rq.off)),
            .wr_dat (rq.dat[WIDTH-1:0]),
            .inc    (inc_a[gi]),
            .acc    (acc_a[gi]),
            .lfsr   (lfsr_a[gi]),
            .ctrl   (ctrl_a[gi]),
            .wrap   (wrap_a[gi]),
            .pwm    (pwm_o[gi])
        );
    end

    logic [NUM_CH-1:0] irq_stat, irq_en;

`ifdef PWM_BANK_IRQ_EN
    logic [NUM_CH-1:0] w1c;
    logic              en_wr;

    assign w1c   = (req & rq.we & rq.glb & (rq.off == G_STAT)) ? rq.dat[NUM_CH-1:0] : '0;
    assign en_wr = req & rq.we & rq.glb & (rq.off == G_EN);

    always_ff @(posedge clk1) begin
        if (!rst1_n) begin
            irq_stat <= '0;
            irq_en   <= '0;
            irq_o    <= 1'b0;
        end else begin
            // OR-ing the new wraps after the clear lets a same-cycle wrap win
            irq_stat <= (irq_stat & ~w1c) | wrap_a;
            if (en_wr) irq_en <= rq.dat[NUM_CH-1:0];
            irq_o    <= |(irq_stat & irq_en);
        end
    end
`else
    logic unused_wrap;

    assign irq_stat    = '0;
    assign irq_en      = '0;
    assign irq_o       = 1'b0;
    assign unused_wrap = &{1'b0, wrap_a};
`endif

    logic [31:0] rd_dat;

    always_comb begin
        rd_dat = FILL;
        if (rq.glb) begin
            case (glb_reg_e'(rq.off))
                G_ID:    rd_dat = {ID_MAGIC, 8'(WIDTH), 8'(NUM_CH)};
                G_STAT:  rd_dat = 32'(irq_stat);
                G_EN:    rd_dat = 32'(irq_en);
                default: rd_dat = FILL;
            endcase
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rq.ch == 4'(i)) begin
                    case (ch_reg_e'(rq.off))
                        REG_INC:  rd_dat = 32'(inc_a[i]);
                        REG_ACC:  rd_dat = 32'(acc_a[i]);
                        REG_LFSR: rd_dat = 32'(lfsr_a[i]);
                        REG_CTRL: rd_dat = 32'(ctrl_a[i]);
                        default:  rd_dat = FILL;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst1_n) begin
            wb.wb_ack   <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            wb.wb_ack <= req;
            if (req & ~rq.we) wb.wb_dat_o <= rd_dat;
        end
    end

    logic unused_bus;
    assign unused_bus = &{1'b0, wb.wb_adr[16:9], wb.wb_adr[1:0], rq.dat};

endmodule

// File: tb/tb_wb_pwm_bank.sv
// Scoreboard bench for wb_pwm_bank: reads queue expected data, the ack monitor pops and compares.
module tb_wb_pwm_bank;

    logic       clk1 = 1'b0;
    logic       rst1_n;
    logic [3:0] pwm_o;
    logic       irq_o;

    wb_pwm_bank_if bif();

    wb_pwm_bank #(.NUM_CH(4), .WIDTH(32)) dut (
        .clk1   (clk1),
        .rst1_n (rst1_n),
        .wb     (bif),
        .pwm_o  (pwm_o),
        .irq_o  (irq_o)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] mask;
    } sb_t;

    sb_t  sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic cur_we = 1'b1;
    logic prev_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v << 1) ^ (v[31] ? 32'h008345E9 : 32'h0);
    endfunction

    task automatic wb_xfer(input logic we, input logic [16:0] adr, input logic [31:0] dat);
        logic got;
        @(negedge clk1); #1;
        cur_we       = we;
        bif.wb_adr   = adr;
        bif.wb_we    = we;
        bif.wb_dat_i = dat;
        bif.wb_cyc   = 1'b1;
        bif.wb_stb   = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk1); #1;
            if (bif.wb_ack) got = 1'b1;
        end
        bif.wb_cyc = 1'b0;
        bif.wb_stb = 1'b0;
        bif.wb_we  = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic wr(input logic [16:0] adr, input logic [31:0] dat);
        wb_xfer(1'b1, adr, dat);
    endtask

    task automatic rd(input string tag, input logic [16:0] adr, input logic [31:0] exp,
                      input logic [31:0] mask = 32'hFFFFFFFF);
        sb_t e;
        e.tag = tag; e.exp = exp; e.mask = mask;
        sb.push_back(e);
        wb_xfer(1'b0, adr, 32'h0);
    endtask

    // ack monitor: single-cycle pulses, read data checked against the scoreboard
    always @(negedge clk1) begin
        if (bif.wb_ack) begin
            chk("ack_gap", 32'(prev_ack), 32'd0);
            if (!cur_we) begin
                if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
                else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk(e.tag, bif.wb_dat_o & e.mask, e.exp & e.mask);
                end
            end
        end
        prev_ack = bif.wb_ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          first;
        logic [31:0] lv;

        rst1_n = 1'b0;
        bif.wb_adr = '0; bif.wb_cyc = 1'b0; bif.wb_stb = 1'b0;
        bif.wb_we = 1'b0; bif.wb_dat_i = '0;
        repeat (3) @(posedge clk1);
        #1;
        chk("rst_ack", 32'(bif.wb_ack), 32'd0);
        chk("rst_dat", bif.wb_dat_o, 32'd0);
        chk("rst_pwm", 32'(pwm_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        @(negedge clk1); rst1_n = 1'b1;

        // reset values and ID
        rd("ch0_inc",  17'h000, 32'd4096);
        rd("ch0_acc",  17'h004, 32'd0);
        rd("ch0_lfsr", 17'h008, 32'hFFFFFFFF);
        rd("ch0_ctrl", 17'h00C, 32'd0);
        rd("id",       17'h100, 32'hB0A12004);

        // accumulator stepping: write ACC, then back-to-back reads 2 cycles apart
        wr(17'h030, 32'd5);
        wr(17'h03C, 32'd1);
        wr(17'h034, 32'd0);
        rd("ch3_acc1", 17'h034, 32'd5);
        rd("ch3_acc2", 17'h034, 32'd15);

        // half-scale increment on ch1
        wr(17'h010, 32'h80000000);
        wr(17'h01C, 32'd1);
        wr(17'h014, 32'd0);
        rd("ch1_inc",  17'h010, 32'h80000000);
        rd("ch1_acc",  17'h014, 32'h80000000);
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk1); #1;
            if (pwm_o[1]) cnt++;
        end
        chk("duty_lo", 32'(cnt >= 150), 32'd1);
        chk("duty_hi", 32'(cnt <= 620), 32'd1);

        // LFSR zero-load and shifting
        wr(17'h028, 32'd0);
        rd("ch2_lfsr0", 17'h028, 32'hFFFFFFFF);
        wr(17'h028, 32'd1);
        wr(17'h02C, 32'd1);
        rd("ch2_lfsr1", 17'h028, 32'h2);
        rd("ch2_lfsr3", 17'h028, 32'h8);
        wr(17'h028, 32'h80000000);
        lv = 32'h80000000;
        rd("ch2_tap", 17'h028, lfsr_step(lv));

        // invert while disabled, unmapped accesses
        wr(17'h03C, 32'd2);
        repeat (2) @(posedge clk1);
        #1 chk("inv_pwm_a", 32'(pwm_o[3]), 32'd1);
        repeat (5) @(posedge clk1);
        #1 chk("inv_pwm_b", 32'(pwm_o[3]), 32'd1);
        rd("ch15_rd", 17'h0F0, 32'hDEADBEEF);
        wr(17'h0F0, 32'h1234);
        wr(17'h0F4, 32'h1234);
        rd("ch0_inc_keep", 17'h000, 32'd4096);
        rd("ch0_acc_keep", 17'h004, 32'd0);
        rd("glb_rsvd", 17'h10C, 32'hDEADBEEF);
`ifdef PWM_BANK_IRQ_EN
        wr(17'h000, 32'h40000000);
        wr(17'h004, 32'd0);
        wr(17'h108, 32'd1);
        wr(17'h104, 32'hF);
        rd("irq_en", 17'h108, 32'd1);
        chk("irq_idle", 32'(irq_o), 32'd0);
        wr(17'h00C, 32'd1);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk1); #1;
            if (irq_o && first == 0) first = k;
        end
        chk("irq_lat", 32'(first), 32'd5);
        // land the W1C on the wrap edge four cycles after the previous one
        repeat (3) @(posedge clk1);
        wr(17'h104, 32'd1);
        rd("stat_setwins", 17'h104, 32'd1, 32'd1);
        wr(17'h00C, 32'd0);
        wr(17'h104, 32'd1);
        rd("stat_clr", 17'h104, 32'd0, 32'd1);
        repeat (2) @(posedge clk1);
        #1 chk("irq_clr", 32'(irq_o), 32'd0);
`else
        first = 0;
        rd("stat_off", 17'h104, 32'd0);
        wr(17'h108, 32'hF);
        rd("en_off", 17'h108, 32'd0);
        chk("irq_off", 32'(irq_o) | 32'(first), 32'd0);
`endif

        // reset during a write: write dropped, no ack
        @(negedge clk1); #1;
        cur_we       = 1'b1;
        bif.wb_adr   = 17'h030;
        bif.wb_we    = 1'b1;
        bif.wb_dat_i = 32'h0000ABCD;
        bif.wb_cyc   = 1'b1;
        bif.wb_stb   = 1'b1;
        rst1_n       = 1'b0;
        @(posedge clk1); #1;
        chk("rstw_ack", 32'(bif.wb_ack), 32'd0);
        chk("rstw_pwm", 32'(pwm_o), 32'd0);
        bif.wb_cyc = 1'b0; bif.wb_stb = 1'b0; bif.wb_we = 1'b0;
        @(negedge clk1); rst1_n = 1'b1;
        rd("rstw_inc",  17'h030, 32'd4096);
        rd("rstw_ctrl", 17'h03C, 32'd0);
        rd("rstw_inc1", 17'h010, 32'd4096);

        repeat (3) @(posedge clk1);
        #1 chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
